c4_rx_deser: RTL

// - Downstream stage of the c4 controller: consumes c4's serial output s, qualified by strobe t.
// - Assembles WIDTH-bit words and buffers them in a small FIFO.
// - Presents words on a valid/ready interface to the next consumer (display/checker logic).
// - Detects framing gaps (timeout) and FIFO overflow.

---
 rtl/c4_pkg.sv | 6 +
 rtl/c4_rx_fifo.sv | 47 ++++
 rtl/c4_rx_deser.sv | 107 ++++++++++
 3 files changed

// File: rtl/c4_pkg.sv
// rtl/c4_pkg.sv - shared types and default sizes for the c4 receive path
package c4_pkg;
   typedef enum logic {IDLE, SHIFT} rx_state_t;
   localparam int C4_WORD_W   = 8;
   localparam int C4_RX_DEPTH = 2;
endpackage

// File: rtl/c4_rx_fifo.sv
// rtl/c4_rx_fifo.sv - word FIFO for the c4 deserializer, count-based full/empty, no fall-through
module c4_rx_fifo
   import c4_pkg::*;
#(
   parameter int WIDTH = C4_WORD_W,
   parameter int DEPTH = C4_RX_DEPTH
) (
   input  logic             n_clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [NW-1:0]    count;
   logic             do_push, do_pop;

   // A push into a full FIFO is still taken when a pop frees the slot on the same edge
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign empty   = (count == '0);
   assign full    = (count == NW'(DEPTH));
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(negedge n_clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + NW'(do_push) - NW'(do_pop);
      end
   end
endmodule

// File: rtl/c4_rx_deser.sv
// rtl/c4_rx_deser.sv - assembles strobed serial bits from c4 into words and queues them for a consumer
module c4_rx_deser
   import c4_pkg::*;
#(
   parameter int WIDTH     = C4_WORD_W,
   parameter int MSB_FIRST = 1,
   parameter int DEPTH     = C4_RX_DEPTH,
   parameter int TIMEOUT   = 16
) (
   input  logic                       n_clk,
   input  logic                       rst,
   input  logic                       s,
   input  logic                       t,
   input  logic                       clr,
   output logic [WIDTH-1:0]           dout,
   output logic                       dvalid,
   input  logic                       dready,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       busy,
   output logic                       tmo,
   output logic                       ovf
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   rx_state_t        state, state_nx;
   logic [CW-1:0]    cnt_nx;
   logic [WIDTH-1:0] sh, sh_nx, base, shifted;
   logic [GW-1:0]    gap, gap_nx;
   logic             expire, push, pop, empty, full;

   assign pop    = dvalid & dready;
   assign dvalid = ~empty;
   assign busy   = (state == SHIFT);
   assign expire = (TIMEOUT != 0) && (state == SHIFT) && !clr && (gap == GW'(TIMEOUT));

   // A new word starts from an all-zero register so stale bits never leak in
   assign base    = (state == IDLE) ? '0 : sh;
   assign shifted = (MSB_FIRST != 0) ? {base[WIDTH-2:0], s} : {s, base[WIDTH-1:1]};

   always_comb begin
      state_nx = state;
      cnt_nx   = bit_cnt;
      sh_nx    = sh;
      gap_nx   = gap;
      push     = 1'b0;
      case (state)
         IDLE: begin
            if (t && !clr) begin
               state_nx = SHIFT;
               cnt_nx   = CW'(1);
               sh_nx    = shifted;
               gap_nx   = '0;
            end
         end
         SHIFT: begin
            if (clr || expire) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               gap_nx   = '0;
            end else if (t) begin
               sh_nx  = shifted;
               gap_nx = '0;
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  push     = 1'b1;
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = bit_cnt + 1'b1;
               end
            end else if (TIMEOUT != 0) begin
               gap_nx = gap + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(negedge n_clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         sh      <= '0;
         gap     <= '0;
         tmo     <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_cnt <= cnt_nx;
         sh      <= sh_nx;
         gap     <= gap_nx;
         tmo     <= expire;
         ovf     <= ovf | (push & full & ~pop);
      end
   end

   c4_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .n_clk (n_clk),
      .rst   (rst),
      .push  (push),
      .din   (shifted),
      .pop   (pop),
      .dout  (dout),
      .empty (empty),
      .full  (full)
   );
endmodule
